// File: rtl/h264_intra_mb_sched.sv
// h264_intra_mb_sched
//
// Frame-level sequencer for the intra 4x4 luma predictor.
// - Pulses NEWSLICE/NEWLINE at frame and line starts.
// - Streams WORDS_MB source words per macroblock into the predictor under READYI.
// - Counts macroblock completions (XXINC).
// - Issues one chroma start token per completed luma macroblock on a rising CHREADY.
// - Holds each line boundary until luma and chroma for that line have drained.
//
// Ports:
//   CLK, RSTN               clock, asynchronous active-low reset
//   START, SLICEPERLINE     frame start pulse, slice-per-line mode
//   SRC_VALID/DATA/READY    source word handshake
//   NEWSLICE, NEWLINE       one-cycle markers to the predictor
//   STROBEI, DATAI, READYI  word stream to the predictor
//   XXINC, CHREADY          predictor completion / chroma-permit inputs
//   CHSTART, CHMBX, CHDONE  chroma token out, chroma completion in
//   MBX, MBY                current feed column, current macroblock line
//   BUSY, FRAMEDONE         frame in progress, end-of-frame pulse
//   STALLCNT                predictor back-pressure cycles (STALL_STATS_EN only)
//
// Optional feature: define STALL_STATS_EN to add the STALLCNT output.
module h264_intra_mb_sched #(
    parameter int unsigned WIDTH_MB  = 8,
    parameter int unsigned HEIGHT_MB = 6,
    parameter int unsigned WORDS_MB  = 64
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic        SLICEPERLINE,
    input  logic        SRC_VALID,
    input  logic [31:0] SRC_DATA,
    output logic        SRC_READY,
    output logic        NEWSLICE,
    output logic        NEWLINE,
    output logic        STROBEI,
    output logic [31:0] DATAI,
    input  logic        READYI,
    input  logic        XXINC,
    input  logic        CHREADY,
    output logic        CHSTART,
    output logic [7:0]  CHMBX,
    input  logic        CHDONE,
    output logic [7:0]  MBX,
    output logic [7:0]  MBY,
    output logic        BUSY,
`ifdef STALL_STATS_EN
    output logic [23:0] STALLCNT,
`endif
    output logic        FRAMEDONE
);

    localparam int unsigned WCW = (WORDS_MB > 1) ? $clog2(WORDS_MB) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS_MB - 1);
    localparam logic [7:0] MB_PER_LINE = 8'(WIDTH_MB);
    localparam logic [7:0] LAST_LINE   = 8'(HEIGHT_MB - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSlice,
        StLine,
        StFeed,
        StDrain
    } state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] word_cnt_q;
    logic [7:0]     feed_mb_q;
    logic [7:0]     done_mb_q;
    logic [7:0]     ch_issued_q;
    logic [7:0]     chroma_pend_q;
    logic [7:0]     mby_q;
    logic           chready_q;
    logic           frame_done_q;
    logic           err_q;

    logic xfer;
    logic mb_last_word;
    logic drain_ok;
    logic xx_ok;
    logic xx_bad;
    logic ch_fire;
    logic chdone_ok;
    logic frame_start;
    logic frame_end;
    logic line_adv;

    // Source-to-predictor path is purely combinational: no buffering, zero latency.
    assign SRC_READY    = READYI & (state_q == StFeed) & (feed_mb_q < MB_PER_LINE);
    assign xfer         = SRC_VALID & SRC_READY;
    assign STROBEI      = xfer;
    assign DATAI        = SRC_DATA;
    assign mb_last_word = xfer & (word_cnt_q == WORD_LAST);

    assign BUSY      = (state_q != StIdle);
    assign MBX       = feed_mb_q;
    assign MBY       = mby_q;
    assign FRAMEDONE = frame_done_q;

    // A completion can never outrun the macroblocks actually fed.
    assign xx_ok  = XXINC & BUSY & (done_mb_q != feed_mb_q);
    assign xx_bad = XXINC & BUSY & (done_mb_q == feed_mb_q);

    // Chroma token on a CHREADY rising edge, only for luma-complete macroblocks.
    assign ch_fire   = CHREADY & ~chready_q & (ch_issued_q < done_mb_q);
    assign CHSTART   = ch_fire;
    assign CHMBX     = ch_fire ? ch_issued_q : 8'd0;
    assign chdone_ok = CHDONE & (chroma_pend_q != 8'd0);

    assign drain_ok = (done_mb_q == MB_PER_LINE) && (chroma_pend_q == 8'd0) &&
                      (ch_issued_q == MB_PER_LINE);

    always_comb begin
        state_d     = state_q;
        NEWSLICE    = 1'b0;
        NEWLINE     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_adv    = 1'b0;
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d     = StSlice;
                    frame_start = 1'b1;
                end
            end
            StSlice: begin
                NEWSLICE = 1'b1;
                NEWLINE  = 1'b1;
                state_d  = StFeed;
            end
            StLine: begin
                NEWLINE  = 1'b1;
                NEWSLICE = SLICEPERLINE;
                state_d  = StFeed;
            end
            StFeed: begin
                if (feed_mb_q == MB_PER_LINE) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_ok) begin
                    if (mby_q == LAST_LINE) begin
                        state_d   = StIdle;
                        frame_end = 1'b1;
                    end else begin
                        state_d  = StLine;
                        line_adv = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= StIdle;
            word_cnt_q    <= '0;
            feed_mb_q     <= 8'd0;
            done_mb_q     <= 8'd0;
            ch_issued_q   <= 8'd0;
            chroma_pend_q <= 8'd0;
            mby_q         <= 8'd0;
            chready_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            chready_q    <= CHREADY;
            frame_done_q <= frame_end;
            if (xx_bad) begin
                err_q <= 1'b1;
            end
            // Counters restart at both frame edges so an idle block reads all zero.
            if (frame_start || frame_end) begin
                word_cnt_q    <= '0;
                feed_mb_q     <= 8'd0;
                done_mb_q     <= 8'd0;
                ch_issued_q   <= 8'd0;
                chroma_pend_q <= 8'd0;
                mby_q         <= 8'd0;
            end else begin
                if (mb_last_word) begin
                    word_cnt_q <= '0;
                    feed_mb_q  <= feed_mb_q + 8'd1;
                end else if (xfer) begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
                if (line_adv) begin
                    mby_q       <= mby_q + 8'd1;
                    feed_mb_q   <= 8'd0;
                    done_mb_q   <= 8'd0;
                    ch_issued_q <= 8'd0;
                end else begin
                    if (xx_ok) begin
                        done_mb_q <= done_mb_q + 8'd1;
                    end
                    if (ch_fire) begin
                        ch_issued_q <= ch_issued_q + 8'd1;
                    end
                end
                // Token and completion in the same cycle cancel out.
                case ({ch_fire, chdone_ok})
                    2'b10:   chroma_pend_q <= chroma_pend_q + 8'd1;
                    2'b01:   chroma_pend_q <= chroma_pend_q - 8'd1;
                    default: chroma_pend_q <= chroma_pend_q;
                endcase
            end
        end
    end

    // Sticky protocol error: more XXINC pulses than macroblocks fed.
    err_never_a: assert property (@(posedge CLK) disable iff (!RSTN) !err_q);

`ifdef STALL_STATS_EN
    logic [23:0] stall_cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt_q <= 24'd0;
        end else if (frame_start) begin
            stall_cnt_q <= 24'd0;
        end else if ((state_q == StFeed) && SRC_VALID && !READYI &&
                     (stall_cnt_q != 24'hFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 24'd1;
        end
    end

    assign STALLCNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_h264_intra_mb_sched.sv
// Testbench for h264_intra_mb_sched: scoreboard of source words and chroma tokens,
// a behavioural predictor/chroma responder, and per-frame marker/count checks.
module tb_h264_intra_mb_sched;

    localparam int unsigned W  = 2;
    localparam int unsigned H  = 3;
    localparam int unsigned WD = 64;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic        SLICEPERLINE = 1'b0;
    logic        SRC_VALID = 1'b0;
    logic [31:0] SRC_DATA = 32'd0;
    logic        READYI = 1'b0;
    logic        XXINC = 1'b0;
    logic        CHREADY = 1'b0;
    logic        CHDONE = 1'b0;
    logic        SRC_READY, NEWSLICE, NEWLINE, STROBEI, CHSTART, BUSY, FRAMEDONE;
    logic [31:0] DATAI;
    logic [7:0]  CHMBX, MBX, MBY;
`ifdef STALL_STATS_EN
    logic [23:0] STALLCNT;
`endif

    h264_intra_mb_sched #(
        .WIDTH_MB (W),
        .HEIGHT_MB(H),
        .WORDS_MB (WD)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .START       (START),
        .SLICEPERLINE(SLICEPERLINE),
        .SRC_VALID   (SRC_VALID),
        .SRC_DATA    (SRC_DATA),
        .SRC_READY   (SRC_READY),
        .NEWSLICE    (NEWSLICE),
        .NEWLINE     (NEWLINE),
        .STROBEI     (STROBEI),
        .DATAI       (DATAI),
        .READYI      (READYI),
        .XXINC       (XXINC),
        .CHREADY     (CHREADY),
        .CHSTART     (CHSTART),
        .CHMBX       (CHMBX),
        .CHDONE      (CHDONE),
        .MBX         (MBX),
        .MBY         (MBY),
        .BUSY        (BUSY),
`ifdef STALL_STATS_EN
        .STALLCNT    (STALLCNT),
`endif
        .FRAMEDONE   (FRAMEDONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;

    int          cyc = 0;
    int          src_idx = 0;
    logic        cur_pushed = 1'b0;
    logic [31:0] exp_q[$];
    logic [7:0]  chx_q[$];
    int          xx_due[$];
    int          chr_due[$];
    int          chd_due[$];

    int   strobes, mb_words, fed_in_line, fed_frame, line_idx, done_frame, ch_cnt;
    int   nl_cnt, ns_cnt, fd_cnt, held_cyc, rel_cyc, rel_nl_cyc, stall_left;
    int   rmode = 0;
    logic spl = 1'b0;
    logic hold_en = 1'b0;
    logic held = 1'b0;
    logic released = 1'b0;
    logic release_req = 1'b0;
    logic start_req = 1'b0;
    logic prev_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [31:0] v;
        v = 32'(i);
        return (v * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_src_ready"}, SRC_READY, 0);
        check_eq({tag, "_newslice"}, NEWSLICE, 0);
        check_eq({tag, "_newline"}, NEWLINE, 0);
        check_eq({tag, "_strobei"}, STROBEI, 0);
        check_eq({tag, "_chstart"}, CHSTART, 0);
        check_eq({tag, "_chmbx"}, CHMBX, 0);
        check_eq({tag, "_mbx"}, MBX, 0);
        check_eq({tag, "_mby"}, MBY, 0);
        check_eq({tag, "_busy"}, BUSY, 0);
        check_eq({tag, "_framedone"}, FRAMEDONE, 0);
`ifdef STALL_STATS_EN
        check_eq({tag, "_stallcnt"}, STALLCNT, 0);
`endif
    endtask

    task automatic clear_model();
        exp_q.delete();
        chx_q.delete();
        xx_due.delete();
        chr_due.delete();
        chd_due.delete();
        cur_pushed  = 1'b0;
        release_req = 1'b0;
    endtask

    task automatic new_frame(input logic s, input int rm, input logic hold, input int stall);
        strobes = 0; mb_words = 0; fed_in_line = 0; fed_frame = 0; line_idx = 0;
        done_frame = 0; ch_cnt = 0; nl_cnt = 0; ns_cnt = 0; fd_cnt = 0;
        held_cyc = 0; rel_cyc = -1; rel_nl_cyc = -1; stall_left = stall;
        spl = s; rmode = rm; hold_en = hold; held = 1'b0; released = 1'b0;
        SLICEPERLINE = s;
    endtask

    // Observe the values the next rising edge will act upon.
    task automatic sample();
        if (!RSTN) begin
            prev_busy = BUSY;
            return;
        end
        if (!READYI) check_eq("src_ready_gate", SRC_READY, 0);
        check_eq("slice_without_line", NEWSLICE & ~NEWLINE, 0);
        if (STROBEI) begin
            check_eq("datai_queue", exp_q.size(), 1);
            if (exp_q.size() > 0) check_eq("datai", DATAI, exp_q.pop_front());
            check_eq("mbx", MBX, fed_in_line);
            check_eq("mby", MBY, line_idx);
            src_idx++;
            cur_pushed = 1'b0;
            strobes++;
            mb_words++;
            if (mb_words == WD) begin
                mb_words = 0;
                fed_in_line++;
                fed_frame++;
                xx_due.push_back(cyc + 30);
            end
        end
        if (NEWLINE) begin
            line_idx = nl_cnt;
            check_eq("newline_mby", MBY, line_idx);
            check_eq("newline_mbx", MBX, 0);
            check_eq("newslice", NEWSLICE, (line_idx == 0) || spl);
            check_eq("partial_mb", mb_words, 0);
            fed_in_line = 0;
            nl_cnt++;
            if (NEWSLICE) ns_cnt++;
            if (rel_cyc >= 0 && rel_nl_cyc < 0) rel_nl_cyc = cyc;
        end
        if (CHSTART) begin
            check_eq("chmbx_queue", chx_q.size(), 1);
            if (chx_q.size() > 0) check_eq("chmbx", CHMBX, chx_q.pop_front());
            if (hold_en && ch_cnt == 1) begin
                held = 1'b1;
                held_cyc = cyc;
            end else begin
                chd_due.push_back(cyc + 5);
            end
            ch_cnt++;
        end
        if (FRAMEDONE) begin
            fd_cnt++;
            check_eq("busy_fall", BUSY, 0);
            check_eq("busy_before_done", prev_busy, 1);
        end
        prev_busy = BUSY;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        START = start_req;
        start_req = 1'b0;
        case (rmode)
            1: READYI = ((cyc / 3) % 2) == 0;
            3: begin
                READYI = 1'b1;
                if (strobes >= 10 && stall_left > 0) begin
                    READYI = 1'b0;
                    stall_left--;
                end
            end
            default: READYI = 1'b1;
        endcase
        SRC_VALID = 1'b1;
        SRC_DATA  = word_of(src_idx);
        if (!cur_pushed) begin
            exp_q.push_back(SRC_DATA);
            cur_pushed = 1'b1;
        end
        XXINC = 1'b0;
        if (xx_due.size() > 0 && xx_due[0] <= cyc) begin
            void'(xx_due.pop_front());
            XXINC = 1'b1;
            chx_q.push_back(8'(done_frame % W));
            done_frame++;
            chr_due.push_back(cyc + 3);
        end
        CHREADY = 1'b0;
        if (chr_due.size() > 0 && chr_due[0] <= cyc) begin
            void'(chr_due.pop_front());
            CHREADY = 1'b1;
        end
        CHDONE = 1'b0;
        if (chd_due.size() > 0 && chd_due[0] <= cyc) begin
            void'(chd_due.pop_front());
            CHDONE = 1'b1;
        end
        if (release_req) begin
            CHDONE = 1'b1;
            release_req = 1'b0;
            rel_cyc = cyc;
        end
        @(negedge CLK);
        sample();
    endtask

    task automatic run_frame(input logic s, input int rm, input logic hold, input logic poke,
                             input int stall);
        int  n;
        logic poked;
        new_frame(s, rm, hold, stall);
        start_req = 1'b1;
        poked = 1'b0;
        n = 0;
        while (fd_cnt == 0 && n < 20000) begin
            tick();
            n++;
            if (poke && !poked && strobes == 100) begin
                start_req = 1'b1;
                poked = 1'b1;
            end
            if (hold && held && !released && cyc == held_cyc + 60) begin
                check_eq("hold_no_newline", nl_cnt, 1);
                check_eq("hold_busy", BUSY, 1);
                release_req = 1'b1;
                released = 1'b1;
            end
        end
        check_eq("frame_finished", n < 20000, 1);
        check_eq("strobes_total", strobes, W * H * WD);
        check_eq("mb_fed_total", fed_frame, W * H);
        check_eq("chstart_total", ch_cnt, W * H);
        check_eq("newline_total", nl_cnt, H);
        check_eq("newslice_total", ns_cnt, s ? H : 1);
        if (hold) check_eq("release_newline_latency", rel_nl_cyc - rel_cyc, 2);
        repeat (3) tick();
        check_eq("framedone_once", fd_cnt, 1);
        check_eq("idle_after_frame", BUSY, 0);
    endtask

    initial begin
        int n;
        READYI = 1'b1;
        SRC_VALID = 1'b1;
        #23;
        check_idle("reset");
        #4 RSTN = 1'b1;

        run_frame(1'b0, 0, 1'b0, 1'b0, 0);
        run_frame(1'b1, 1, 1'b0, 1'b1, 0);
        run_frame(1'b0, 0, 1'b1, 1'b0, 0);

        // Reset in the middle of the second macroblock of line 0.
        new_frame(1'b0, 0, 1'b0, 0);
        start_req = 1'b1;
        n = 0;
        while (!(fed_frame == 1 && mb_words == 20) && n < 5000) begin
            tick();
            n++;
        end
        check_eq("midrst_reached", n < 5000, 1);
        #1 RSTN = 1'b0;
        #1 check_idle("midrst");
        check_eq("midrst_no_framedone", fd_cnt, 0);
        clear_model();
        repeat (3) tick();
        #2 RSTN = 1'b1;
        run_frame(1'b0, 0, 1'b0, 1'b0, 0);

`ifdef STALL_STATS_EN
        run_frame(1'b0, 3, 1'b0, 1'b0, 17);
        check_eq("stallcnt", STALLCNT, 17);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
